// File: rtl/context_error_update.sv
// JPEG-LS error stage: bias-corrects the prediction, maps the modulo error for the
// Golomb coder, and updates the per-context A/B/C/N statistics. One sample per clock.
module context_error_update #(
  parameter int NUM_CTX = 365,
  parameter int RESET_N = 64,
  parameter int A_INIT  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       en_in,
  input  logic [8:0] Q,
  input  logic       sign,
  input  logic [8:0] Ix,
  input  logic [8:0] Px,
  output logic       ready,
  output logic       en_out,
  output logic [8:0] errval,
  output logic [8:0] merrval,
  output logic [3:0] k
);
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic [15:0]       a;
    logic signed [7:0] b;
    logic signed [7:0] c;
    logic [6:0]        n;
  } ctx_t;

  ctx_t ctx_mem [NUM_CTX];
  ctx_t cur, upd, init_ctx;

  logic [0:0] state_q, state_d;
  logic [8:0] ctr_q, ctr_d;
  logic       accept, q_ok;
  logic       en_out_q;
  logic [8:0] errval_q, merrval_q;
  logic [3:0] k_q, k_d;

  logic signed [11:0] c_x, b_x, n_x, px_p, e, e_abs, m, b_u, n_u;
  logic [16:0]        a_u;
  logic signed [7:0]  c_u;
  logic               found, special;
  logic               unused;

  assign init_ctx = '{a: 16'(A_INIT), b: 8'sd0, c: 8'sd0, n: 7'd1};
  assign ready    = (state_q == ST_RUN);
  assign accept   = ready && en_in && !frame_start;
  assign q_ok     = int'(Q) < NUM_CTX;
  assign cur      = q_ok ? ctx_mem[Q] : init_ctx;

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    if (state_q == ST_INIT) begin
      ctr_d = ctr_q + 9'd1;
      if (int'(ctr_q) == NUM_CTX - 1) begin
        state_d = ST_RUN;
        ctr_d   = '0;
      end
    end else if (frame_start) begin
      state_d = ST_INIT;
      ctr_d   = '0;
    end
  end

  // Bias-corrected prediction, modulo-reduced error, Golomb k and mapped error
  always_comb begin
    c_x  = {{4{cur.c[7]}}, cur.c};
    b_x  = {{4{cur.b[7]}}, cur.b};
    n_x  = {5'b0, cur.n};
    px_p = sign ? ({3'b0, Px} - c_x) : ({3'b0, Px} + c_x);
    if (px_p < 12'sd0)        px_p = '0;
    else if (px_p > 12'sd255) px_p = 12'sd255;
    e = {3'b0, Ix} - px_p;
    if (sign) e = -e;
    if (e < -12'sd128)      e = e + 12'sd256;
    else if (e > 12'sd127)  e = e - 12'sd256;
    e_abs = e[11] ? -e : e;

    k_d   = 4'd15;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!found && ((32'(cur.n) << i) >= 32'(cur.a))) begin
        k_d   = 4'(i);
        found = 1'b1;
      end
    end

    special = (k_d == 4'd0) && ((b_x <<< 1) <= -n_x);
    if (!e[11]) m = special ? (e <<< 1) + 12'sd1 : (e <<< 1);
    else        m = special ? -(e <<< 1) - 12'sd2 : -(e <<< 1) - 12'sd1;
  end

  // Statistics update; B is kept in (-N, 0] and C steers the bias one step at a time
  always_comb begin
    a_u = {1'b0, cur.a} + {5'b0, e_abs};
    b_u = b_x + e;
    n_u = n_x;
    c_u = cur.c;
    if (cur.n == 7'(RESET_N)) begin
      a_u = a_u >> 1;
      b_u = b_u >>> 1;
      n_u = n_x >>> 1;
    end
    n_u = n_u + 12'sd1;
    if (b_u <= -n_u) begin
      b_u = b_u + n_u;
      if (cur.c > -8'sd128) c_u = cur.c - 8'sd1;
      if (b_u <= -n_u) b_u = 12'sd1 - n_u;
    end else if (b_u > 12'sd0) begin
      b_u = b_u - n_u;
      if (cur.c < 8'sd127) c_u = cur.c + 8'sd1;
      if (b_u > 12'sd0) b_u = '0;
    end
    upd.a = a_u[15:0];
    upd.b = b_u[7:0];
    upd.c = c_u;
    upd.n = n_u[6:0];
  end

  assign unused = ^{e[11:9], m[11:9], a_u[16], b_u[11:8], n_u[11:7]};

  // Context array carries no reset: INIT rewrites every entry before use
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT)  ctx_mem[ctr_q] <= init_ctx;
    else if (accept && q_ok) ctx_mem[Q]     <= upd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_INIT;
      ctr_q     <= '0;
      en_out_q  <= 1'b0;
      errval_q  <= '0;
      merrval_q <= '0;
      k_q       <= '0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      en_out_q  <= accept;
      errval_q  <= accept ? e[8:0] : '0;
      merrval_q <= accept ? m[8:0] : '0;
      k_q       <= accept ? k_d : '0;
    end
  end

  assign en_out  = en_out_q;
  assign errval  = errval_q;
  assign merrval = merrval_q;
  assign k       = k_q;
endmodule

// File: tb/tb_context_error_update.sv
// Randomised bench for context_error_update: integer reference model of the context
// statistics feeds a scoreboard; a negedge monitor checks every presented result.
module tb_context_error_update;
  localparam int NCTX = 365;

  logic       clk = 1'b0, reset = 1'b0, frame_start = 1'b0, en_in = 1'b0, sign = 1'b0;
  logic [8:0] Q = '0, Ix = '0, Px = '0;
  logic       ready, en_out;
  logic [8:0] errval, merrval;
  logic [3:0] k;

  always #5 clk = ~clk;

  context_error_update dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .en_in(en_in),
    .Q(Q), .sign(sign), .Ix(Ix), .Px(Px),
    .ready(ready), .en_out(en_out), .errval(errval), .merrval(merrval), .k(k)
  );

  typedef struct { int e; int m; int k; int cyc; bit dc; } exp_t;
  exp_t sb[$];
  exp_t mr;
  int mA[NCTX], mB[NCTX], mC[NCTX], mN[NCTX];
  int nchk = 0, nfail = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic init_model();
    for (int i = 0; i < NCTX; i++) begin
      mA[i] = 4; mB[i] = 0; mC[i] = 0; mN[i] = 1;
    end
  endtask

  task automatic model(input int q, input int s, input int ix, input int px, output exp_t r);
    int pp, e, kk, me;
    r.dc = 0; r.e = 0; r.m = 0; r.k = 0; r.cyc = 0;
    if (q >= NCTX) begin
      r.dc = 1;
      return;
    end
    pp = s ? px - mC[q] : px + mC[q];
    if (pp < 0)   pp = 0;
    if (pp > 255) pp = 255;
    e = s ? pp - ix : ix - pp;
    if (e < -128)     e += 256;
    else if (e > 127) e -= 256;
    kk = 0;
    while ((mN[q] << kk) < mA[q]) kk++;
    me = (e >= 0) ? 2 * e : -2 * e - 1;
    if (kk == 0 && 2 * mB[q] <= -mN[q]) me = (e >= 0) ? 2 * e + 1 : -2 * e - 2;
    r.e = e; r.m = me; r.k = kk;
    mB[q] += e;
    mA[q] += (e < 0) ? -e : e;
    if (mN[q] == 64) begin
      mA[q] /= 2;
      mB[q] = (mB[q] < 0) ? -((1 - mB[q]) / 2) : mB[q] / 2;
      mN[q] /= 2;
    end
    mN[q] += 1;
    if (mB[q] <= -mN[q]) begin
      mB[q] += mN[q];
      if (mC[q] > -128) mC[q]--;
      if (mB[q] <= -mN[q]) mB[q] = 1 - mN[q];
    end else if (mB[q] > 0) begin
      mB[q] -= mN[q];
      if (mC[q] < 127) mC[q]++;
      if (mB[q] > 0) mB[q] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int q, input int s, input int ix, input int px);
    Q = 9'(q); sign = 1'(s); Ix = 9'(ix); Px = 9'(px); en_in = 1'b1;
  endtask

  task automatic send(input int q, input int s, input int ix, input int px);
    exp_t r;
    drive(q, s, ix, px);
    model(q, s, ix, px, r);
    r.cyc = cyc;
    sb.push_back(r);
    tick();
  endtask

  // Model still tracks the context, but the expected outputs are the given constants
  task automatic send_exp(input int q, input int s, input int ix, input int px,
                          input int e, input int m, input int kk);
    exp_t r;
    drive(q, s, ix, px);
    model(q, s, ix, px, r);
    r.e = e; r.m = m; r.k = kk; r.cyc = cyc;
    sb.push_back(r);
    tick();
  endtask

  task automatic idle();
    en_in = 1'b0;
    tick();
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!ready && n < 2000) begin
      drive($urandom_range(0, NCTX - 1), $urandom_range(0, 1), $urandom_range(0, 255),
            $urandom_range(0, 255));
      en_in = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    en_in = 1'b0;
    chk(nm, n, NCTX);
    init_model();
  endtask

  task automatic send_random(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else send(($urandom_range(0, 19) == 0) ? $urandom_range(NCTX, 511) : $urandom_range(0, 15),
                $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (en_out) begin
        if (sb.size() == 0) begin
          nchk++; nfail++;
          $display("FAIL spurious_en_out: en_out=1 with no accepted sample pending (t=%0t)", $time);
        end else begin
          mr = sb.pop_front();
          chk("latency", cyc, mr.cyc + 1);
          if (!mr.dc) begin
            chk("errval", $signed(errval), mr.e);
            chk("merrval", merrval, mr.m);
            chk("k", k, mr.k);
          end
        end
      end else begin
        chk("idle_outputs_zero", {errval, merrval, k}, 0);
      end
    end
  end

  initial begin
    init_model();
    repeat (3) tick();
    chk("rst_ready", ready, 0);
    chk("rst_en_out", en_out, 0);
    chk("rst_outputs", {errval, merrval, k}, 0);
    reset = 1'b1;
    wait_ready("init_cycles");

    send_exp(0, 0, 100, 98, 2, 4, 2);
    send_exp(0, 0, 100, 98, 1, 2, 2);
    send_exp(5, 1, 10, 200, -66, 131, 2);
    idle();

    for (int i = 0; i < 64; i++)  send(7, 0, 100 + mC[7] + 3, 100);
    for (int i = 0; i < 200; i++) send(7, 0, mC[7] + 100, 0);
    for (int i = 0; i < 20; i++)  send(7, 0, $urandom_range(0, 255), 200);
    idle();

    send_random(600);
    idle();

    drive(0, 0, 100, 98);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("fs_ready_drop", ready, 0);
    wait_ready("fs_init_cycles");
    send_exp(0, 0, 100, 98, 2, 4, 2);
    send_exp(0, 0, 100, 98, 1, 2, 2);
    send_random(100);
    idle();

    drive(3, 0, 50, 60);
    reset = 1'b0;
    #1;
    chk("rst_mid_ready", ready, 0);
    chk("rst_mid_en_out", en_out, 0);
    repeat (3) tick();
    reset = 1'b1;
    wait_ready("rst_init_cycles");
    send_exp(0, 0, 100, 98, 2, 4, 2);
    send_exp(0, 0, 100, 98, 1, 2, 2);
    send_random(50);
    idle();
    idle();

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
